pattern_serializer: RTL
=======================

// Module: pattern_serializer
// PURPOSE
//  Upstream feeder for the serial pattern detectors. Accepts parallel words over a valid/ready
//  handshake and shifts them out one bit per clock as the detector input stream x.
//  Consecutive words are sent with no gap between them, using a one-word holding register.
//  Also provides a bit-valid qualifier and a word-start marker for downstream stages.
// PARAMETERS
//  WIDTH      4   bits per word; must be >= 2
//  LSB_FIRST  0   0: shift MSB first; 1: shift LSB first
//  IDLE_BIT   0   value driven on x while no word is being shifted
// PORTS
//  clk        in   1      clock; all state changes on the rising edge
//  rst        in   1      asynchronous, active-low reset
//  din        in   WIDTH  parallel word to serialize
//  din_valid  in   1      din holds a word
//  din_ready  out  1      block can take a word this cycle
//  x          out  1      serial bit to the detector
//  x_valid    out  1      x carries a real data bit
//  x_first    out  1      x is bit 0 of a word (first bit sent)
//  busy       out  1      shifting, or a word is waiting in the holding register
// BEHAVIOUR
//  - Accept happens on a rising edge where din_valid && din_ready are both 1.
//  - din_ready = rst && (!hold_full || last); last = (state==SHIFT && cnt==WIDTH-1).
//    This is combinational. No words are accepted while rst is low.
//  - State: shift reg sr[WIDTH], bit counter cnt[$clog2(WIDTH)], hold[WIDTH], hold_full, FSM {IDLE, SHIFT}.
//  - Reset (async, rst=0): state=IDLE, sr=0, cnt=0, hold_full=0.
//    Outputs during reset: x=IDLE_BIT, x_valid=0, x_first=0, busy=0, din_ready=0.
//  - IDLE: x=IDLE_BIT, x_valid=0.
//    On accept: sr<=din, cnt<=0, go to SHIFT. Latency: first bit appears on x the cycle after the accept edge.
//  - SHIFT: x = sr[WIDTH-1] (MSB first) or sr[0] (LSB first); x_valid=1; x_first=(cnt==0).
//    - When not last: sr shifts toward the output end by one bit; cnt++.
//      An accept here loads hold<=din and sets hold_full<=1.
//    - When last and hold_full: sr<=hold, cnt<=0, stay in SHIFT.
//      If there is also an accept on this edge: hold<=din and hold_full stays 1; otherwise hold_full<=0.
//    - When last, hold empty, and an accept: sr<=din, cnt<=0, stay in SHIFT (no bubble).
//    - When last, hold empty, and no accept: go to IDLE.
//  - Throughput: one bit per clock continuously as long as din_valid keeps up.
//    x_valid never drops between back-to-back words.
//  - busy = (state==SHIFT) || hold_full.
//  - din is sampled only on the accept edge. A change to din while din_ready=0 has no effect.
//  - Reset mid-word: the in-flight word and any held word are discarded immediately (async).
//    After release, the next accepted word starts cleanly with x_first=1.
//  - cnt wraps only through explicit reload to 0; it never counts past WIDTH-1.
//  - The serial x/x_valid/x_first outputs come straight from flops/sr.
//    Only din_ready is combinational.
// STRUCTURE
//  - Shared package pattern_pkg: FSM encodings ST_IDLE=1'b0, ST_SHIFT=1'b1;
//    default WIDTH constant PAT_WORD_W=4.
//  - One natural sub-module: pattern_hold_reg, a WIDTH-bit register with a full flag and load/take strobes.
//  - The FSM and shifter stay in the top module.
// TESTING  (WIDTH=4 unless noted)
//  - Reset: hold rst=0 with din_valid=1 -> din_ready=0, x=0, x_valid=0.
//    Release -> din_ready=1, busy=0.
//  - Single word 4'b1001, one-cycle valid -> x=1,0,0,1 on the next 4 cycles; x_first only on the first.
//    Then x_valid=0 and busy=0. A detector fed by x flags a match on the 4th bit.
//  - Back-to-back 4'hA then 4'h5, valid held -> 8 contiguous valid bits 1,0,1,0,0,1,0,1.
//    din_ready drops while hold_full and no last bit.
//  - Accept coinciding with the last bit, hold empty (word 4'h3 then 4'hC) -> no x_valid gap.
//    x_first pulses at bit 0 and bit 4.
//  - Assert rst at bit 2 of 4'hF with 4'h0 held -> x=IDLE_BIT and x_valid=0 immediately.
//    After release, 4'h6 shifts 0,1,1,0 with no remnant bits.
//  - LSB_FIRST=1, IDLE_BIT=1, word 4'b0011 -> x=1,1,0,0; then x stays 1 with x_valid=0.

Source files
------------

// File: rtl/pattern_pkg.sv
// pattern_pkg: shared FSM encoding and default word width for the pattern serializer
package pattern_pkg;
  localparam int PAT_WORD_W = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
endpackage

// File: rtl/pattern_hold_reg.sv
// pattern_hold_reg: one-word holding register with full flag and load/take strobes
module pattern_hold_reg
  import pattern_pkg::*;
#(
  parameter int WIDTH = PAT_WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      full <= 1'b0;
    end else begin
      if (load) q <= d;
      // A simultaneous take and load keeps the register full with the new word
      full <= load | (full & ~take);
    end
  end
endmodule

// File: rtl/pattern_serializer.sv
// pattern_serializer: valid/ready parallel-to-serial feeder with a one-word holding register
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH     = PAT_WORD_W,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             x_first,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             last;
  logic             acc;
  logic             load;
  logic             take;
  assign last      = (state == ST_SHIFT) && (cnt == CW'(WIDTH - 1));
  assign din_ready = rst && (!hold_full || last);
  assign acc       = din_valid && din_ready;
  // On the last bit with an empty hold, a new word goes straight into sr
  assign load      = acc && (state == ST_SHIFT) && (!last || hold_full);
  assign take      = last && hold_full;
  assign x         = (state == ST_SHIFT) ? (LSB_FIRST ? sr[0] : sr[WIDTH-1]) : IDLE_BIT;
  assign x_valid   = (state == ST_SHIFT);
  assign x_first   = x_valid && (cnt == '0);
  assign busy      = x_valid || hold_full;
  pattern_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .take (take),
    .d    (din),
    .q    (hold),
    .full (hold_full)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else if (state == ST_IDLE) begin
      if (acc) begin
        sr    <= din;
        cnt   <= '0;
        state <= ST_SHIFT;
      end
    end else if (!last) begin
      sr  <= LSB_FIRST ? (sr >> 1) : (sr << 1);
      cnt <= cnt + 1'b1;
    end else if (hold_full) begin
      sr  <= hold;
      cnt <= '0;
    end else if (acc) begin
      sr  <= din;
      cnt <= '0;
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule
